// File: rtl/stage4_mem.sv
// Memory stage: word-addressed data memory plus the MEM/WB pipeline register.
// Define STAGE4_FWD_EN to add the fwd_valid/fwd_rd/fwd_data forwarding outputs into EX.
module stage4_mem #(
   parameter int Width = 32,
   parameter int Depth = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall,
   input  logic             flush,
   input  logic [Width-1:0] ALUResult_in,
   input  logic [Width-1:0] WriteData,
   input  logic [4:0]       controlsignals_in,
   input  logic [4:0]       Rd_in,
   output logic [Width-1:0] readData,
   output logic [Width-1:0] ALUResult,
   output logic [2:0]       controlsignals,
   output logic [4:0]       Rd,
`ifdef STAGE4_FWD_EN
   output logic             fwd_valid,
   output logic [4:0]       fwd_rd,
   output logic [Width-1:0] fwd_data,
`endif
   output logic             addr_err
);

   localparam int AW = (Depth > 1) ? $clog2(Depth) : 1;

   logic [Width-1:0] mem [Depth];

   logic             mem_read;
   logic             mem_write;
   logic             bad_addr;
   logic             do_write;
   logic [AW-1:0]    index;
   logic [Width-1:0] rdata;

   // NOTE: every signal is assigned on every path through this block, so no latch can be inferred.
   always_comb begin
      mem_read  = controlsignals_in[4];
      mem_write = controlsignals_in[3];
      index     = ALUResult_in[AW+1:2];
      bad_addr  = (mem_read | mem_write) &
                  ((ALUResult_in[1:0] != 2'b00) | (|ALUResult_in[Width-1:AW+2]));
      do_write  = mem_write & ~bad_addr & ~stall & ~flush & ~rst;
      // Read sees the pre-edge contents, which gives read-before-write on a combined access.
      rdata     = (mem_read & ~bad_addr) ? mem[index] : '0;
   end

   // NOTE: the array is cleared on reset because loads after reset must return 0;
   // this costs a wide reset fan-out that a plain RAM macro could not provide.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < Depth; i++) mem[i] <= '0;
      end else if (do_write) begin
         mem[index] <= WriteData;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         readData       <= '0;
         ALUResult      <= '0;
         controlsignals <= '0;
         Rd             <= '0;
         addr_err       <= 1'b0;
      end else if (!stall) begin
         readData       <= rdata;
         ALUResult      <= ALUResult_in;
         // A faulting access must never commit to the register file.
         controlsignals <= {controlsignals_in[2], controlsignals_in[1] & ~bad_addr,
                            controlsignals_in[0]};
         Rd             <= Rd_in;
         addr_err       <= bad_addr;
      end
   end

`ifdef STAGE4_FWD_EN
   assign fwd_data  = controlsignals[2] ? readData : ALUResult;
   assign fwd_valid = controlsignals[1] & (Rd != 5'd0);
   assign fwd_rd    = Rd;
`else
   // Forwarding outputs are not present in this build.
`endif

endmodule

// File: tb/tb_stage4_mem.sv
// Scoreboard bench for stage4_mem: each row's expected MEM/WB contents are queued
// when the row is driven and compared one cycle later.
module tb_stage4_mem;

   typedef struct packed {
      logic [31:0] rdata;
      logic [31:0] alu;
      logic [2:0]  ctl;
      logic [4:0]  rd;
      logic        err;
   } out_t;

   typedef struct packed {
      logic        rst;
      logic        stall;
      logic        flush;
      logic [31:0] alu;
      logic [31:0] wd;
      logic [4:0]  ctl;
      logic [4:0]  rd;
      out_t        exp;
   } stim_t;

   localparam logic [4:0] C_ST = 5'b01000;
   localparam logic [4:0] C_LD = 5'b10110;
   localparam logic [4:0] C_OP = 5'b00010;
   localparam logic [4:0] C_RW = 5'b11110;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        stall = 1'b0;
   logic        flush = 1'b0;
   logic [31:0] ALUResult_in = '0;
   logic [31:0] WriteData = '0;
   logic [4:0]  controlsignals_in = '0;
   logic [4:0]  Rd_in = '0;
   logic [31:0] readData;
   logic [31:0] ALUResult;
   logic [2:0]  controlsignals;
   logic [4:0]  Rd;
   logic        addr_err;
`ifdef STAGE4_FWD_EN
   logic        fwd_valid;
   logic [4:0]  fwd_rd;
   logic [31:0] fwd_data;
`endif

   out_t  obs;
   out_t  e;
   out_t  sb[$];
   int    n_cmp = 0;
   int    n_bad = 0;

   assign obs = {readData, ALUResult, controlsignals, Rd, addr_err};

   stage4_mem #(.Width(32), .Depth(64)) dut (
      .clk(clk),
      .rst(rst),
      .stall(stall),
      .flush(flush),
      .ALUResult_in(ALUResult_in),
      .WriteData(WriteData),
      .controlsignals_in(controlsignals_in),
      .Rd_in(Rd_in),
      .readData(readData),
      .ALUResult(ALUResult),
      .controlsignals(controlsignals),
      .Rd(Rd),
`ifdef STAGE4_FWD_EN
      .fwd_valid(fwd_valid),
      .fwd_rd(fwd_rd),
      .fwd_data(fwd_data),
`endif
      .addr_err(addr_err)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic out_t o(input logic [31:0] rdv, input logic [31:0] alu,
                              input logic [2:0] ctl, input logic [4:0] rdn, input logic err);
      o = {rdv, alu, ctl, rdn, err};
   endfunction

   function automatic stim_t row(input logic r, input logic st, input logic fl,
                                 input logic [31:0] alu, input logic [31:0] wd,
                                 input logic [4:0] ctl, input logic [4:0] rdn, input out_t ex);
      row = {r, st, fl, alu, wd, ctl, rdn, ex};
   endfunction

   // Drive one instruction for the next edge and queue what MEM/WB must hold after it.
   task automatic apply(input stim_t s);
      rst               = s.rst;
      stall             = s.stall;
      flush             = s.flush;
      ALUResult_in      = s.alu;
      WriteData         = s.wd;
      controlsignals_in = s.ctl;
      Rd_in             = s.rd;
      sb.push_back(s.exp);
   endtask

   task automatic test_reset();
      stim_t rows[$];
      rows.push_back(row(1, 0, 0, 32'h0, 32'h0, 5'b0, 5'd0, o(0, 0, 3'b000, 0, 0)));
      rows.push_back(row(0, 0, 0, 32'h10, 32'h77, C_ST, 5'd3, o(0, 32'h10, 3'b000, 3, 0)));
      rows.push_back(row(0, 0, 0, 32'h10, 32'h0, C_LD, 5'd1, o(32'h77, 32'h10, 3'b110, 1, 0)));
      rows.push_back(row(1, 1, 0, 32'h10, 32'h0, C_LD, 5'd1, o(0, 0, 3'b000, 0, 0)));
      rows.push_back(row(0, 0, 0, 32'h10, 32'h0, C_LD, 5'd1, o(0, 32'h10, 3'b110, 1, 0)));
      foreach (rows[i]) begin
         apply(rows[i]);
         @(posedge clk); #1;
         e = sb.pop_front();
         n_cmp++;
         if (obs !== e) begin
            n_bad++;
            $display("FAIL reset[%0d]: got rd=%h alu=%h ctl=%b rd#=%0d err=%b required rd=%h alu=%h ctl=%b rd#=%0d err=%b",
                     i, obs.rdata, obs.alu, obs.ctl, obs.rd, obs.err, e.rdata, e.alu, e.ctl, e.rd, e.err);
         end
      end
   endtask

   task automatic test_store_load();
      stim_t rows[$];
      rows.push_back(row(0, 0, 0, 32'h08, 32'hDEADBEEF, C_ST, 5'd0, o(0, 32'h08, 3'b000, 0, 0)));
      rows.push_back(row(0, 0, 0, 32'h08, 32'h0, C_LD, 5'd5, o(32'hDEADBEEF, 32'h08, 3'b110, 5, 0)));
      foreach (rows[i]) begin
         apply(rows[i]);
         @(posedge clk); #1;
         e = sb.pop_front();
         n_cmp++;
         if (obs !== e) begin
            n_bad++;
            $display("FAIL store_load[%0d]: got rd=%h alu=%h ctl=%b rd#=%0d err=%b required rd=%h alu=%h ctl=%b rd#=%0d err=%b",
                     i, obs.rdata, obs.alu, obs.ctl, obs.rd, obs.err, e.rdata, e.alu, e.ctl, e.rd, e.err);
         end
      end
   endtask

   task automatic test_stall();
      stim_t rows[$];
      out_t  held_a;
      out_t  held_b;
      held_a = o(0, 32'h99, 3'b010, 9, 0);
      held_b = o(32'h1234, 32'h0C, 3'b110, 4, 0);
      rows.push_back(row(0, 0, 0, 32'h99, 32'h0, C_OP, 5'd9, held_a));
      rows.push_back(row(0, 1, 0, 32'h0C, 32'h1234, C_ST, 5'd2, held_a));
      rows.push_back(row(0, 1, 0, 32'h0C, 32'h1234, C_ST, 5'd2, held_a));
      rows.push_back(row(0, 0, 0, 32'h0C, 32'h1234, C_ST, 5'd2, o(0, 32'h0C, 3'b000, 2, 0)));
      rows.push_back(row(0, 0, 0, 32'h0C, 32'h0, C_LD, 5'd4, held_b));
      rows.push_back(row(0, 1, 0, 32'h14, 32'hBAD, C_ST, 5'd2, held_b));
      rows.push_back(row(0, 0, 0, 32'h14, 32'h0, C_LD, 5'd4, o(0, 32'h14, 3'b110, 4, 0)));
      foreach (rows[i]) begin
         apply(rows[i]);
         @(posedge clk); #1;
         e = sb.pop_front();
         n_cmp++;
         if (obs !== e) begin
            n_bad++;
            $display("FAIL stall[%0d]: got rd=%h alu=%h ctl=%b rd#=%0d err=%b required rd=%h alu=%h ctl=%b rd#=%0d err=%b",
                     i, obs.rdata, obs.alu, obs.ctl, obs.rd, obs.err, e.rdata, e.alu, e.ctl, e.rd, e.err);
         end
      end
   endtask

   task automatic test_flush();
      stim_t rows[$];
      rows.push_back(row(0, 0, 0, 32'h04, 32'hA5A5, C_ST, 5'd0, o(0, 32'h04, 3'b000, 0, 0)));
      rows.push_back(row(0, 1, 1, 32'h04, 32'h55, C_ST, 5'd6, o(0, 0, 3'b000, 0, 0)));
      rows.push_back(row(0, 0, 0, 32'h04, 32'h0, C_LD, 5'd6, o(32'hA5A5, 32'h04, 3'b110, 6, 0)));
      rows.push_back(row(0, 0, 1, 32'h100, 32'h0, C_LD, 5'd8, o(0, 0, 3'b000, 0, 0)));
      foreach (rows[i]) begin
         apply(rows[i]);
         @(posedge clk); #1;
         e = sb.pop_front();
         n_cmp++;
         if (obs !== e) begin
            n_bad++;
            $display("FAIL flush[%0d]: got rd=%h alu=%h ctl=%b rd#=%0d err=%b required rd=%h alu=%h ctl=%b rd#=%0d err=%b",
                     i, obs.rdata, obs.alu, obs.ctl, obs.rd, obs.err, e.rdata, e.alu, e.ctl, e.rd, e.err);
         end
      end
   endtask

   task automatic test_addr_err();
      stim_t rows[$];
      rows.push_back(row(0, 0, 0, 32'h06, 32'hCAFE, C_ST, 5'd1, o(0, 32'h06, 3'b000, 1, 1)));
      rows.push_back(row(0, 0, 0, 32'h04, 32'h0, C_LD, 5'd6, o(32'hA5A5, 32'h04, 3'b110, 6, 0)));
      rows.push_back(row(0, 0, 0, 32'h100, 32'h0, C_LD, 5'd8, o(0, 32'h100, 3'b100, 8, 1)));
      rows.push_back(row(0, 0, 0, 32'hFC, 32'h5A5A, C_ST, 5'd0, o(0, 32'hFC, 3'b000, 0, 0)));
      rows.push_back(row(0, 0, 0, 32'hFC, 32'h0, C_LD, 5'd8, o(32'h5A5A, 32'hFC, 3'b110, 8, 0)));
      rows.push_back(row(0, 0, 0, 32'h103, 32'h0, C_OP, 5'd3, o(0, 32'h103, 3'b010, 3, 0)));
      rows.push_back(row(0, 0, 0, 32'h0A, 32'h0, C_LD, 5'd3, o(0, 32'h0A, 3'b100, 3, 1)));
      foreach (rows[i]) begin
         apply(rows[i]);
         @(posedge clk); #1;
         e = sb.pop_front();
         n_cmp++;
         if (obs !== e) begin
            n_bad++;
            $display("FAIL addr_err[%0d]: got rd=%h alu=%h ctl=%b rd#=%0d err=%b required rd=%h alu=%h ctl=%b rd#=%0d err=%b",
                     i, obs.rdata, obs.alu, obs.ctl, obs.rd, obs.err, e.rdata, e.alu, e.ctl, e.rd, e.err);
         end
      end
   endtask

   task automatic test_back_to_back();
      stim_t rows[$];
      rows.push_back(row(0, 0, 0, 32'h08, 32'h2222, C_RW, 5'd3, o(32'hDEADBEEF, 32'h08, 3'b110, 3, 0)));
      rows.push_back(row(0, 0, 0, 32'h08, 32'h0, C_LD, 5'd3, o(32'h2222, 32'h08, 3'b110, 3, 0)));
      rows.push_back(row(0, 0, 0, 32'h20, 32'h11, C_ST, 5'd0, o(0, 32'h20, 3'b000, 0, 0)));
      rows.push_back(row(0, 0, 0, 32'h24, 32'h22, C_ST, 5'd0, o(0, 32'h24, 3'b000, 0, 0)));
      rows.push_back(row(0, 0, 0, 32'h20, 32'h0, C_LD, 5'd1, o(32'h11, 32'h20, 3'b110, 1, 0)));
      rows.push_back(row(0, 0, 0, 32'h24, 32'h0, C_LD, 5'd2, o(32'h22, 32'h24, 3'b110, 2, 0)));
      foreach (rows[i]) begin
         apply(rows[i]);
         @(posedge clk); #1;
         e = sb.pop_front();
         n_cmp++;
         if (obs !== e) begin
            n_bad++;
            $display("FAIL back_to_back[%0d]: got rd=%h alu=%h ctl=%b rd#=%0d err=%b required rd=%h alu=%h ctl=%b rd#=%0d err=%b",
                     i, obs.rdata, obs.alu, obs.ctl, obs.rd, obs.err, e.rdata, e.alu, e.ctl, e.rd, e.err);
         end
      end
   endtask

`ifdef STAGE4_FWD_EN
   task automatic test_fwd();
      stim_t       rows[$];
      logic [37:0] fq[$];
      logic [37:0] fe;
      logic [37:0] fo;
      rows.push_back(row(0, 0, 0, 32'h30, 32'hAA, C_ST, 5'd0, o(0, 32'h30, 3'b000, 0, 0)));
      fq.push_back({1'b0, 5'd0, 32'h30});
      rows.push_back(row(0, 0, 0, 32'h30, 32'h0, C_LD, 5'd7, o(32'hAA, 32'h30, 3'b110, 7, 0)));
      fq.push_back({1'b1, 5'd7, 32'hAA});
      rows.push_back(row(0, 0, 0, 32'h44, 32'h0, C_OP, 5'd0, o(0, 32'h44, 3'b010, 0, 0)));
      fq.push_back({1'b0, 5'd0, 32'h44});
      rows.push_back(row(0, 0, 0, 32'h44, 32'h0, C_OP, 5'd12, o(0, 32'h44, 3'b010, 12, 0)));
      fq.push_back({1'b1, 5'd12, 32'h44});
      rows.push_back(row(1, 0, 0, 32'h44, 32'h0, C_OP, 5'd12, o(0, 0, 3'b000, 0, 0)));
      fq.push_back({1'b0, 5'd0, 32'h0});
      foreach (rows[i]) begin
         apply(rows[i]);
         @(posedge clk); #1;
         e  = sb.pop_front();
         fe = fq.pop_front();
         fo = {fwd_valid, fwd_rd, fwd_data};
         n_cmp++;
         if (obs !== e) begin
            n_bad++;
            $display("FAIL fwd_mem[%0d]: got rd=%h alu=%h ctl=%b rd#=%0d err=%b required rd=%h alu=%h ctl=%b rd#=%0d err=%b",
                     i, obs.rdata, obs.alu, obs.ctl, obs.rd, obs.err, e.rdata, e.alu, e.ctl, e.rd, e.err);
         end
         n_cmp++;
         if (fo !== fe) begin
            n_bad++;
            $display("FAIL fwd[%0d]: got valid=%b rd=%0d data=%h required valid=%b rd=%0d data=%h",
                     i, fo[37], fo[36:32], fo[31:0], fe[37], fe[36:32], fe[31:0]);
         end
      end
   endtask
`endif

   initial begin
      test_reset();
      test_store_load();
      test_stall();
      test_flush();
      test_addr_err();
      test_back_to_back();
`ifdef STAGE4_FWD_EN
      test_fwd();
`endif
      n_cmp++;
      if (sb.size() != 0) begin
         n_bad++;
         $display("FAIL scoreboard_drain: got %0d entries left required 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/stage4_mem.md
Name: stage4_mem

Overview:
- Memory stage of the 5-stage pipeline, directly upstream of the writeback stage.
- Holds the word-addressed data memory and performs loads and stores using the ALU result as the address.
- Owns the MEM/WB pipeline register, whose outputs drive the writeback stage's readData, ALUResult, controlsignals[2:0] and Rd inputs.
- Supports stall, flush and address-error detection.

Parameters:
- Width, 32, datapath width in bits.
- Depth, 64, number of data-memory words (power of two, 2..1024).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- stall  input  1  hold the MEM/WB register and suppress the memory write.
- flush  input  1  insert a bubble into MEM/WB and suppress the memory write.
- ALUResult_in  input  Width  byte address for loads/stores; passthrough value otherwise.
- WriteData  input  Width  store data.
- controlsignals_in  input  5  [4]=MemRead, [3]=MemWrite, [2]=MemtoReg, [1]=RegWrite, [0]=spare.
- Rd_in  input  5  destination register.
- readData  output  Width  registered load data.
- ALUResult  output  Width  registered ALU result.
- controlsignals  output  3  registered {MemtoReg, RegWrite, spare}.
- Rd  output  5  registered destination register.
- addr_err  output  1  registered; the instruction now in MEM/WB had a bad memory address.

Behaviour:
- Clocking: one clock, clk; reset is synchronous and active-high on rst. All state updates on the rising edge of clk.
- Reset (rst=1 at an edge):
  - All outputs go to 0 and all memory words are cleared to 0 in that same cycle.
  - rst overrides stall and flush.
- Address decode:
  - Word index = ALUResult_in[log2(Depth)+1:2].
  - bad_addr = (MemRead|MemWrite) & ((ALUResult_in[1:0]!=0) | (any ALUResult_in bit above log2(Depth)+1 set)).
- Store: mem[index] <= WriteData when MemWrite & ~bad_addr & ~stall & ~flush & ~rst. Every other case leaves memory unchanged.
- Load data:
  - rdata = mem[index] read combinationally when MemRead & ~bad_addr; otherwise rdata = 0.
  - rdata is captured into readData, giving 1-cycle latency to the writeback stage.
- Simultaneous MemRead and MemWrite:
  - The store is performed.
  - readData captures the pre-write word (read-before-write).
- Store then load to the same address in the next cycle: the load returns the newly stored word.
- MEM/WB register update, in priority order:
  1. rst: all outputs cleared.
  2. flush: bubble. readData, ALUResult, controlsignals, Rd all 0; addr_err = 0.
  3. stall: all outputs hold.
  4. Otherwise:
     - readData <= rdata.
     - ALUResult <= ALUResult_in.
     - controlsignals <= controlsignals_in[2:0].
     - Rd <= Rd_in.
     - addr_err <= bad_addr.
- On bad_addr, the RegWrite bit captured into controlsignals[1] is forced to 0 so the writeback stage does not commit it.
- Release after a stall: the held instruction is followed by the current inputs. Nothing is lost or duplicated, provided the upstream stage also holds during the stall.
- No internal state machine beyond the memory array and the MEM/WB register. Throughput is one instruction per cycle.

Optional Feature:
- STAGE4_FWD_EN defined:
  - Adds outputs fwd_valid (1), fwd_rd (5) and fwd_data (Width) for forwarding into EX.
  - fwd_data = controlsignals[2] ? readData : ALUResult.
  - fwd_valid = controlsignals[1] & (Rd!=0).
  - fwd_rd = Rd.
  - All three are combinational from the MEM/WB register, so all are 0 after reset or flush.
- Not defined: these ports and their logic are absent. Behaviour is otherwise identical.

Test Plan:
- Reset: hold rst=1 for 1 cycle -> all outputs 0; a load from 0x10 afterwards returns 0.
- Store/load pair:
  - Stimulus: store 0xDEADBEEF to 0x08 (ctrl=01000), then load 0x08 with ctrl=10110 and Rd=5.
  - Required: the cycle after the load, readData=0xDEADBEEF, controlsignals=3'b110, Rd=5.
- Stall:
  - Stimulus: assert stall for 2 cycles during a store of 0x1234 to 0x0C.
  - Required: outputs hold, memory unchanged; after release the store lands and a load of 0x0C returns 0x1234.
- Flush vs stall:
  - Stimulus: flush=1 and stall=1 together with a store of 0x55 to 0x04.
  - Required: MEM/WB all 0, mem[1] unchanged.
- Address errors:
  - Misaligned store to 0x06 -> no write, addr_err=1.
  - Load from 0x100 with Depth=64 -> readData=0, addr_err=1, controlsignals[1]=0.
- With STAGE4_FWD_EN:
  - Stimulus: load to Rd=7 returning 0xAA.
  - Required: fwd_valid=1, fwd_rd=7, fwd_data=0xAA.
  - Stimulus: ALU-op with Rd=0 and RegWrite=1.
  - Required: fwd_valid=0.
